// File: rtl/register_set_sb.sv
// Parametrised register file with async reads, one sync write port, per-register
// scoreboard bits and a sequenced bulk-clear engine. Optional macro: WRITE_BYPASS_EN.
module register_set_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pend1,
    output logic              rd_pend2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_stall,
    input  logic              clear_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W-1:0] counter;
    logic              wr_ok;
    logic              iss_ok;

    assign busy      = (state == CLEAR);
    assign wr_ok     = wr_en & ~busy;
    assign iss_stall = busy | pending[iss_addr];
    assign iss_ok    = iss_en & ~iss_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_req) state_next = CLEAR;
            CLEAR:   if (counter == ADDR_W'(DEPTH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the register file is built from flops, not a RAM macro, so reset can and must clear every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
            counter <= '0;
        end else if (busy) begin
            regs[counter]    <= '0;
            pending[counter] <= 1'b0;
            counter          <= counter + ADDR_W'(1);
        end else begin
            if (wr_ok) begin
                regs[wr_addr]    <= wr_data;
                pending[wr_addr] <= 1'b0;
            end
            // Issue is applied after the write so a same-address issue keeps the pending bit set.
            if (iss_ok) begin
                pending[iss_addr] <= 1'b1;
            end
            if (clear_req) begin
                counter <= '0;
            end
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        rd_pend1 = pending[rd_addr1];
        rd_pend2 = pending[rd_addr2];
`ifdef WRITE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_pend1 = 1'b0;
        end
        if (wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_pend2 = 1'b0;
        end
`else
        if (wr_ok && (wr_addr == rd_addr1) && (wr_addr == rd_addr2)) begin
            // Stored contents only; a same-cycle write becomes visible after the edge.
        end
`endif
    end

endmodule
